v810_ifetch: RTL

Instruction fetch/prefetch queue for the V810 core, sitting between the decoder and the memory access unit's instruction bus (ICI). It requests aligned 32-bit words over ICI, splits them into halfwords, buffers up to 8 halfwords, and presents the next one or two halfwords with their PC to the decoder. It also handles branch redirects, including discarding a fetch that is already in flight.

---
 rtl/v810_ifetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/v810_ifetch.sv
// ---------------------------------------------------------------------------
// v810_ifetch
//
// Instruction fetch / prefetch queue for the V810 core. Sits between the
// decoder and the memory access unit's instruction bus (ICI). Aligned 32-bit
// words are requested over ICI, split into halfwords and buffered in an
// 8-entry halfword ring. The head halfword, the one after it, and the PC of
// the head are presented to the decoder. Branch redirects flush the queue and
// discard a fetch that is already in flight.
//
// Ports:
//   CLK        core clock
//   RES        asynchronous active-high reset
//   CE         global clock enable; state advances only when CE=1
//   BR_REQ     redirect request (branch, jump, exception vector)
//   BR_PC      redirect target, bit 0 ignored
//   ICIA       fetch word address, bits [1:0] always 0
//   ICIREQ     fetch request, held with ICIA until ICIACK
//   ICID       fetch data, valid in the ICIACK cycle
//   ICIACK     fetch acknowledge
//   IF_PC      address of the head halfword
//   IF_HW0     head halfword
//   IF_HW1     halfword after the head
//   IF_VALID   at least one halfword queued
//   IF_VALID2  at least two halfwords queued
//   IF_TAKE    halfwords consumed this cycle (0, 1 or 2)
// ---------------------------------------------------------------------------
module v810_ifetch (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        BR_REQ,
    input  logic [31:0] BR_PC,
    output logic [31:0] ICIA,
    output logic        ICIREQ,
    input  logic [31:0] ICID,
    input  logic        ICIACK,
    output logic [31:0] IF_PC,
    output logic [15:0] IF_HW0,
    output logic [15:0] IF_HW1,
    output logic        IF_VALID,
    output logic        IF_VALID2,
    input  logic [1:0]  IF_TAKE
);

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

    // Halfword ring and its bookkeeping
    logic [15:0] q_q [8];
    logic [15:0] q_d [8];
    logic [2:0]  rptr_q, rptr_d;
    logic [2:0]  wptr_q, wptr_d;
    logic [3:0]  count_q, count_d;

    // Fetch address, odd-start flag and in-flight discard marker
    logic [31:0] fa_q, fa_d;
    logic        fa_odd_q, fa_odd_d;
    logic        discard_q, discard_d;

    // Bus request and decoder PC
    logic        req_q, req_d;
    logic [31:0] icia_q, icia_d;
    logic [31:0] pc_q, pc_d;

    logic        outstanding;
    logic [2:0]  rptr_plus1;

    // Bit 0 of the redirect target is meaningless for halfword-aligned code
    logic        unused_br_pc0;
    assign unused_br_pc0 = BR_PC[0];

    assign rptr_plus1 = rptr_q + 3'd1;

    assign ICIA      = icia_q;
    assign ICIREQ    = req_q;
    assign IF_PC     = pc_q;
    assign IF_HW0    = q_q[rptr_q];
    assign IF_HW1    = q_q[rptr_plus1];
    assign IF_VALID  = (count_q != 4'd0);
    assign IF_VALID2 = (count_q >= 4'd2);

    // Next-state logic. A redirect wins over everything else in the cycle:
    // the queue is emptied, any simultaneous take is ignored and the ack data
    // (if any) is dropped. If the bus still owes us data after this cycle the
    // redirect marks it for discard so the stale word never enters the queue.
    // The request decision looks at the post-update count so that a request
    // can go out the cycle right after an ack or after the decoder frees room.
    always_comb begin
        q_d         = q_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        fa_d        = fa_q;
        fa_odd_d    = fa_odd_q;
        discard_d   = discard_q;
        pc_d        = pc_q;
        req_d       = req_q;
        icia_d      = icia_q;
        outstanding = req_q && !ICIACK;

        if (CE) begin
            if (BR_REQ) begin
                rptr_d    = wptr_q;
                count_d   = 4'd0;
                pc_d      = {BR_PC[31:1], 1'b0};
                fa_d      = {BR_PC[31:2], 2'b00};
                fa_odd_d  = BR_PC[1];
                discard_d = outstanding;
            end else begin
                if (req_q && ICIACK) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (fa_odd_q) begin
                        // Redirect landed on the upper halfword of this word
                        q_d[wptr_q] = ICID[31:16];
                        wptr_d      = wptr_q + 3'd1;
                        count_d     = count_q + 4'd1;
                        fa_odd_d    = 1'b0;
                        fa_d        = fa_q + 32'd4;
                    end else begin
                        q_d[wptr_q]        = ICID[15:0];
                        q_d[wptr_q + 3'd1] = ICID[31:16];
                        wptr_d             = wptr_q + 3'd2;
                        count_d            = count_q + 4'd2;
                        fa_d               = fa_q + 32'd4;
                    end
                end
                rptr_d  = rptr_q + {1'b0, IF_TAKE};
                pc_d    = pc_q + {29'd0, IF_TAKE, 1'b0};
                count_d = count_d - {2'b00, IF_TAKE};
            end

            // A raised request is frozen until its ack arrives
            if (!outstanding) begin
                req_d  = !discard_d && (count_d <= 4'd6);
                icia_d = fa_d;
            end
        end
    end

    // State register. Reset drops any in-flight request immediately so the
    // bus never sees ICIREQ held across reset.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < 8; i++) begin
                q_q[i] <= 16'h0000;
            end
            rptr_q    <= 3'd0;
            wptr_q    <= 3'd0;
            count_q   <= 4'd0;
            fa_q      <= RESET_PC;
            fa_odd_q  <= 1'b0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            icia_q    <= RESET_PC;
            pc_q      <= RESET_PC;
        end else begin
            q_q       <= q_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            fa_q      <= fa_d;
            fa_odd_q  <= fa_odd_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            icia_q    <= icia_d;
            pc_q      <= pc_d;
        end
    end

    // The decoder must never consume more than is queued, nor request 3
    take_legal: assert property (@(posedge CLK) disable iff (RES)
        (CE && !BR_REQ) |-> (IF_TAKE != 2'd3 && {2'b00, IF_TAKE} <= count_q));

endmodule
